// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared types and constants for the handshaked data memory:
//               access-size encodings, FSM state type, store trace format.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    // Access size as carried on req_size
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Request/response sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Committed-store trace: time, pc, word address, merged word
    localparam string c_TRACE_FMT = "%d@%h: *%h <= %h";

    // True when the byte offset is not a multiple of the access size
    function automatic logic size_misaligned(input size_e sz, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (sz)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_unit.sv
`default_nettype none
// ============================================================================
// Module      : dm_lane_unit
// Description : Combinational byte-lane steering. Merges store data into the
//               old memory word and extracts/extends load data from it.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [4:0]  w_bsel;
    logic [4:0]  w_hsel;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Bit positions of the addressed byte lane and half-word lane pair
    assign w_bsel = {off, 3'b000};
    assign w_hsel = {off[1], 4'b0000};
    assign w_byte = old_word[w_bsel +: 8];
    assign w_half = old_word[w_hsel +: 16];

    // Lane merge for stores, lane extract plus sign/zero extension for loads
    always_comb begin
        merged = old_word;
        rdata  = 32'd0;
        case (size)
            SZ_BYTE: begin
                merged[w_bsel +: 8] = wdata[7:0];
                rdata = {{24{~is_unsigned & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                merged[w_hsel +: 16] = wdata[15:0];
                rdata = {{16{~is_unsigned & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                merged = wdata;
                rdata  = old_word;
            end
            default: begin
                merged = old_word;
                rdata  = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_hs_mem.sv
`default_nettype none
// ============================================================================
// Module      : dm_hs_mem
// Description : Data memory with valid/ready request and response channels,
//               programmable access latency, byte/half/word accesses and
//               misalignment / range / reserved-size error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_hs_mem
    import dm_pkg::*;
#(
    parameter int          DEPTH       = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0,
    parameter bit          TRACE       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          c_AW   = $clog2(DEPTH);
    // Byte span of the array; 33 bits so a negative offset compares as huge
    localparam logic [32:0] c_SPAN = 33'(DEPTH) << 2;

    state_e      r_state;
    state_e      w_next;
    logic [3:0]  r_cnt;
    logic        r_alive;

    logic        r_we;
    size_e       r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;

    logic [31:0] r_rdata;
    logic        r_err;

    // Backing array; zero at time 0, deliberately untouched by reset
    logic [31:0] r_mem [DEPTH] = '{default: 32'd0};

    logic        w_accept;
    logic        w_access;
    logic        w_commit;
    logic [32:0] w_diff;
    logic        w_err;
    logic [c_AW-1:0] w_idx;
    logic [31:0] w_old;
    logic [31:0] w_merged;
    logic [31:0] w_load;

    assign w_accept = req_valid && req_ready;
    assign w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);

    // Offset from the array base; bit 32 set means the address is below it
    assign w_diff = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign w_err  = (r_size == SZ_RSVD)
                 || size_misaligned(r_size, r_addr[1:0])
                 || (w_diff >= c_SPAN);
    assign w_idx  = w_diff[c_AW+1:2];
    assign w_old  = r_mem[w_idx];
    assign w_commit = w_access && r_we && !w_err;

    dm_lane_unit u_lane (
        .old_word    (w_old),
        .wdata       (r_wdata),
        .size        (r_size),
        .off         (r_addr[1:0]),
        .is_unsigned (r_uns),
        .merged      (w_merged),
        .rdata       (w_load)
    );

    // State register; r_alive holds req_ready low until the first edge after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next;
            r_alive <= 1'b1;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = r_alive;
                if (w_accept) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) w_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Latency counter: loaded on accept, counts down while waiting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'(WAIT_CYCLES);
        end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture; fields stay constant for the whole access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_uns   <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_pc    <= 32'd0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_size  <= size_e'(req_size);
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_pc    <= req_pc;
        end
    end

    // Response payload: set on the access edge, cleared when consumed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
            r_err   <= w_err;
        end else if ((r_state == ST_RESP) && resp_ready) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Array write port: read-modify-write result of a committed store
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    generate
        if (TRACE) begin : g_trace
`ifndef SYNTHESIS
            // Simulation trace of every committed store
            always_ff @(posedge clk) begin
                if (w_commit) begin
                    $display(c_TRACE_FMT, $time, r_pc, {r_addr[31:2], 2'b00}, w_merged);
                end
            end
`endif
        end else begin : g_no_trace
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dm_hs_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_hs_mem
// Description : Self-checking bench for dm_hs_mem: directed steps followed by
//               random traffic, checked against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_hs_mem;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          WAITC = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] g_rd;
    logic        g_err;

    // Reference memory as a flat little-endian byte array
    logic [7:0] mdl [DEPTH*4];

    dm_hs_mem #(
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAITC),
        .TRACE       (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_pc       (req_pc),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: error rules, byte-lane store, extended load
    function automatic void mdl_access(input logic we, input logic [1:0] sz, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
        longint      off;
        int          nb;
        logic [31:0] v;
        off = longint'(addr) - longint'(BASE);
        er  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
              (sz == 2'b10 && addr[1:0] != 2'b00) || (off < 0) || (off >= DEPTH * 4);
        rd  = 32'd0;
        if (!er) begin
            nb = 1 << sz;
            if (we) begin
                for (int i = 0; i < nb; i++) mdl[int'(off) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[int'(off) + i];
                if (!uns && nb < 4 && v[8*nb-1])
                    for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                rd = v;
            end
        end
    endfunction

    // One complete request/response transaction with optional backpressure
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int bp);
        int          n;
        logic [31:0] erd;
        logic        eer;
        logic [31:0] crd;
        logic        cer;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_pc       = req_pc + 32'd4;
        resp_ready   = (bp == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, WAITC + 1);
        mdl_access(we, sz, uns, addr, wd, erd, eer);
        g_rd  = resp_rdata;
        g_err = resp_err;
        chk("rdata", resp_rdata, erd);
        chk("err", {31'd0, resp_err}, {31'd0, eer});
        if (bp > 0) begin
            crd = resp_rdata;
            cer = resp_err;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("bp_valid", {31'd0, resp_valid}, 32'd1);
                chk("bp_rdata", resp_rdata, crd);
                chk("bp_err", {31'd0, resp_err}, {31'd0, cer});
                chk("bp_ready", {31'd0, req_ready}, 32'd0);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("resp_done", {31'd0, resp_valid}, 32'd0);
        chk("rdata_clr", resp_rdata, 32'd0);
        chk("err_clr", {31'd0, resp_err}, 32'd0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < DEPTH * 4; i++) mdl[i] = 8'h00;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_pc       = 32'h0040_0000;
        resp_ready   = 1'b1;

        // Reset state
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_req_ready_pre", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // Word store and load back
        xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 0);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        chk("lw_10_a", g_rd, 32'h1234_5678);

        // Byte store, signed and unsigned byte loads
        xact(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 0);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        chk("lw_10_b", g_rd, 32'h1234_AB78);
        xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0);
        chk("lb_11", g_rd, 32'hFFFF_FFAB);
        xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
        chk("lbu_11", g_rd, 32'h0000_00AB);

        // Half store, half and byte loads
        xact(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 0);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        chk("lw_10_c", g_rd, 32'h8001_AB78);
        xact(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
        chk("lh_12", g_rd, 32'hFFFF_8001);
        xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
        chk("lhu_12", g_rd, 32'h0000_8001);
        xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
        chk("lb_13", g_rd, 32'hFFFF_FF80);

        // Error cases
        xact(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0);
        chk("lw_mis_err", {31'd0, g_err}, 32'd1);
        xact(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_FFFF, 0);
        chk("sh_mis_err", {31'd0, g_err}, 32'd1);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        chk("lw_10_d", g_rd, 32'h8001_AB78);
        xact(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
        chk("rsvd_err", {31'd0, g_err}, 32'd1);
        xact(1'b0, 2'b10, 1'b0, BASE + DEPTH * 4, 32'h0, 0);
        chk("range_err", {31'd0, g_err}, 32'd1);
        xact(1'b0, 2'b10, 1'b0, BASE + DEPTH * 4 - 4, 32'h0, 0);
        chk("range_last_ok", {31'd0, g_err}, 32'd0);

        // Backpressure on the response channel
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
        chk("lw_10_bp", g_rd, 32'h8001_AB78);

        // Reset while a store is waiting: outputs clear, store is dropped
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_rdata", resp_rdata, 32'd0);
        chk("mid_rst_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
        chk("lw_20_dropped", g_rd, 32'h0000_0000);

        // Random traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) sz = 2'b11;
            if ($urandom_range(0, 7) == 0) begin
                a = 32'($urandom_range(0, DEPTH * 4 + 64));
            end else begin
                a = 32'($urandom_range(0, 63));
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                 a, $urandom, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
